// File: rtl/space_invaders_pkg.sv
// Shared screen bounds, colours and fleet FSM encoding for the invaders blocks.
package space_invaders_pkg;

    localparam int SCREEN_X_MAX   = 319;
    localparam int SCREEN_Y_LIMIT = 200;

    localparam logic [2:0] BLACK        = 3'b000;
    localparam logic [2:0] ALIEN_COLOUR = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        MOVE,
        DRAW,
        DONE
    } fleet_state_e;

    function automatic int fleet_span(input int cols, input int sprite_w, input int gap);
        return cols * sprite_w + (cols - 1) * gap;
    endfunction

endpackage

// File: rtl/sprite_raster.sv
// Walks every pixel of each masked alien, one per cycle; the first pixel is
// presented combinationally in the start cycle so the caller can register it.
module sprite_raster import space_invaders_pkg::*; #(
    parameter int COLS     = 4,
    parameter int SPRITE_W = 10,
    parameter int SPRITE_H = 4,
    parameter int GAP      = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [9:0]      org_x_i,
    input  logic [9:0]      org_y_i,
    input  logic [COLS-1:0] mask_i,
    output logic [8:0]      x_o,
    output logic [7:0]      y_o,
    output logic            valid_o,
    output logic            last_o
);

    localparam int AW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RW    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int PITCH = SPRITE_W + GAP;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [AW:0] find_from(input logic [COLS-1:0] m, input int from);
        logic [AW:0] r;
        r = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = {1'b1, AW'(i)};
        end
        return r;
    endfunction

    logic            active_q, active_d;
    logic [AW-1:0]   alien_q, alien_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [COLS-1:0] mask_q;
    logic [9:0]      ox_q, oy_q;

    logic [COLS-1:0] cur_mask;
    logic [AW-1:0]   cur_alien;
    logic [RW-1:0]   cur_row;
    logic [CW-1:0]   cur_col;
    logic [9:0]      cur_ox, cur_oy;
    logic            cur_valid, end_col, end_row;
    logic [AW:0]     first, nxt;

    always_comb begin
        cur_mask  = mask_q;
        cur_alien = alien_q;
        cur_row   = row_q;
        cur_col   = col_q;
        cur_ox    = ox_q;
        cur_oy    = oy_q;
        cur_valid = active_q;
        first     = find_from(mask_i, 0);
        if (start_i) begin
            cur_mask  = mask_i;
            cur_alien = first[AW-1:0];
            cur_row   = '0;
            cur_col   = '0;
            cur_ox    = org_x_i;
            cur_oy    = org_y_i;
            cur_valid = first[AW];
        end

        nxt     = find_from(cur_mask, int'(cur_alien) + 1);
        end_col = (cur_col == CW'(SPRITE_W - 1));
        end_row = (cur_row == RW'(SPRITE_H - 1));

        active_d = cur_valid;
        alien_d  = cur_alien;
        row_d    = cur_row;
        col_d    = cur_col;
        if (cur_valid) begin
            if (!end_col) begin
                col_d = cur_col + 1'b1;
            end else begin
                col_d = '0;
                if (!end_row) begin
                    row_d = cur_row + 1'b1;
                end else begin
                    row_d    = '0;
                    alien_d  = nxt[AW-1:0];
                    active_d = nxt[AW];
                end
            end
        end

        valid_o = cur_valid;
        last_o  = cur_valid & end_col & end_row & ~nxt[AW];
        x_o     = 9'(cur_ox + 10'(cur_alien) * 10'(PITCH) + 10'(cur_col));
        y_o     = 8'(cur_oy + 10'(cur_row));
    end

    always_ff @(posedge clk) begin
        if (!reset) active_q <= 1'b0;
        else        active_q <= active_d;
    end

    always_ff @(posedge clk) begin
        alien_q <= alien_d;
        row_q   <= row_d;
        col_q   <= col_d;
        mask_q  <= cur_mask;
        ox_q    <= cur_ox;
        oy_q    <= cur_oy;
    end

endmodule

// File: rtl/alien_fleet.sv
// Space-invaders fleet: on each tick erase the old frame, step the fleet, redraw.
// The raster runs one cycle ahead of the registered pixel outputs.
module alien_fleet import space_invaders_pkg::*; #(
    parameter int         COLS     = 4,
    parameter int         SPRITE_W = 10,
    parameter int         SPRITE_H = 4,
    parameter int         GAP      = 6,
    parameter int         STEP     = 1,
    parameter int         DROP     = 1,
    parameter int         X_START  = 100,
    parameter int         X_MAX    = SCREEN_X_MAX,
    parameter int         Y_LIMIT  = SCREEN_Y_LIMIT,
    parameter logic [2:0] COLOUR   = ALIEN_COLOUR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [COLS-1:0] alive,
    output logic [8:0]      x,
    output logic [7:0]      y,
    output logic [2:0]      colour,
    output logic            plot,
    output logic            busy,
    output logic            done,
    output logic [8:0]      fleet_x,
    output logic [7:0]      fleet_y,
    output logic            landed
);

    localparam int SPAN = fleet_span(COLS, SPRITE_W, GAP);

    fleet_state_e    state_q, state_d;
    logic [8:0]      fleet_x_q, fleet_x_d;
    logic [7:0]      fleet_y_q, fleet_y_d;
    logic            dir_right_q, dir_right_d;
    logic [COLS-1:0] drawn_mask_q, drawn_mask_d;
    logic [COLS-1:0] new_mask_q, new_mask_d;
    logic            landed_q, landed_d;

    logic [8:0]      x_q;
    logic [7:0]      y_q;
    logic [2:0]      colour_q;
    logic            plot_q, last_q;

    logic            r_start, r_valid, r_last;
    logic [9:0]      r_ox, r_oy;
    logic [COLS-1:0] r_mask;
    logic [8:0]      r_x;
    logic [7:0]      r_y;
    logic [2:0]      pix_colour;
    logic [9:0]      fx10, fy10;

    sprite_raster #(
        .COLS     (COLS),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .GAP      (GAP)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .start_i (r_start),
        .org_x_i (r_ox),
        .org_y_i (r_oy),
        .mask_i  (r_mask),
        .x_o     (r_x),
        .y_o     (r_y),
        .valid_o (r_valid),
        .last_o  (r_last)
    );

    always_comb begin
        state_d      = state_q;
        fleet_x_d    = fleet_x_q;
        fleet_y_d    = fleet_y_q;
        dir_right_d  = dir_right_q;
        drawn_mask_d = drawn_mask_q;
        new_mask_d   = new_mask_q;
        r_start      = 1'b0;
        r_mask       = drawn_mask_q;
        r_ox         = {1'b0, fleet_x_q};
        r_oy         = {2'b00, fleet_y_q};
        pix_colour   = BLACK;
        fx10         = {1'b0, fleet_x_q};
        fy10         = {2'b00, fleet_y_q};

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    new_mask_d = alive;
                    r_start    = |drawn_mask_q;
                    state_d    = (|drawn_mask_q) ? ERASE : MOVE;
                end
            end
            ERASE: begin
                // last_q marks the final erase pixel being shown this cycle
                if (last_q) state_d = MOVE;
            end
            MOVE: begin
                if (!landed_q) begin
                    if (dir_right_q) begin
                        if (fx10 + 10'(SPAN - 1 + STEP) <= 10'(X_MAX)) begin
                            fleet_x_d = 9'(fx10 + 10'(STEP));
                        end else begin
                            fleet_y_d   = 8'(fy10 + 10'(DROP));
                            dir_right_d = 1'b0;
                        end
                    end else begin
                        if (fx10 >= 10'(STEP)) begin
                            fleet_x_d = 9'(fx10 - 10'(STEP));
                        end else begin
                            fleet_y_d   = 8'(fy10 + 10'(DROP));
                            dir_right_d = 1'b1;
                        end
                    end
                end
                // Draw origin is the post-move position, first pixel emitted now
                r_start    = 1'b1;
                r_mask     = new_mask_q;
                r_ox       = {1'b0, fleet_x_d};
                r_oy       = {2'b00, fleet_y_d};
                pix_colour = COLOUR;
                state_d    = (|new_mask_q) ? DRAW : DONE;
            end
            DRAW: begin
                pix_colour = COLOUR;
                if (last_q) state_d = DONE;
            end
            DONE: begin
                drawn_mask_d = new_mask_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        landed_d = landed_q | (({2'b00, fleet_y_d} + 10'(SPRITE_H - 1)) >= 10'(Y_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            fleet_x_q    <= 9'(X_START);
            fleet_y_q    <= '0;
            dir_right_q  <= 1'b0;
            drawn_mask_q <= '0;
            landed_q     <= 1'b0;
            plot_q       <= 1'b0;
            last_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
        end else begin
            state_q      <= state_d;
            fleet_x_q    <= fleet_x_d;
            fleet_y_q    <= fleet_y_d;
            dir_right_q  <= dir_right_d;
            drawn_mask_q <= drawn_mask_d;
            landed_q     <= landed_d;
            plot_q       <= r_valid;
            last_q       <= r_last;
            if (r_valid) begin
                x_q      <= r_x;
                y_q      <= r_y;
                colour_q <= pix_colour;
            end
        end
    end

    always_ff @(posedge clk) begin
        new_mask_q <= new_mask_d;
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign fleet_x = fleet_x_q;
    assign fleet_y = fleet_y_q;
    assign landed  = landed_q;

endmodule
